cursor_ctrl: RTL and testbench

CURSOR_CTRL -- requirements
Module: cursor_ctrl

---
 rtl/cursor_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_cursor_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_ctrl.sv
// cursor_ctrl - board cursor driven by four direction buttons and a select button.
//
// Raw buttons are synchronized (two flops), debounced, and turned into one-cycle
// press events. A three-state direction FSM (idle / delay / repeat) moves the
// cursor once on a press and then auto-repeats while the button stays held.
//
// Optional feature (macro CURSOR_WRAP_EN):
//   defined   - moving past an edge wraps to the opposite edge.
//   undefined - the cursor saturates at the edge and no move_valid pulse is given.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_btn   in   asynchronous active-high reset
//   touch_btn   in   [3:0] raw direction buttons, active-low: 0=up 1=down 2=left 3=right
//   select_btn  in   raw select button, active-high
//   cursor_row  out  [3:0] registered cursor row
//   cursor_col  out  [3:0] registered cursor column
//   move_valid  out  one-cycle pulse when the cursor position changes
//   sel_valid   out  one-cycle pulse on an accepted select press
module cursor_ctrl #(
   parameter int unsigned GRID_N          = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_RATE     = 10_000_000
) (
   input  logic       clk,
   input  logic       reset_btn,
   input  logic [3:0] touch_btn,
   input  logic       select_btn,
   output logic [3:0] cursor_row,
   output logic [3:0] cursor_col,
   output logic       move_valid,
   output logic       sel_valid
);

`ifdef CURSOR_WRAP_EN
   localparam bit WrapEn = 1'b1;
`else
   localparam bit WrapEn = 1'b0;
`endif

   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned TmrW   = $clog2(TmrMax + 1);

   localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TmrW-1:0] TmrDelay = TmrW'(REPEAT_DELAY);
   localparam logic [TmrW-1:0] TmrRate  = TmrW'(REPEAT_RATE);
   localparam logic [TmrW-1:0] TmrOne   = TmrW'(1);
   localparam logic [3:0]      Last     = 4'(GRID_N - 1);

   // Raw released levels: touch buttons idle high, select idles low.
   localparam logic [4:0] SyncRst = 5'b0_1111;

   localparam logic [1:0] DirUp    = 2'd0;
   localparam logic [1:0] DirDown  = 2'd1;
   localparam logic [1:0] DirLeft  = 2'd2;
   localparam logic [1:0] DirRight = 2'd3;

   typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

   // ------------------------------------------------------------------
   // Synchronizers; bit 4 is select, bits 3:0 are the direction buttons
   // ------------------------------------------------------------------
   logic [4:0] sync1_q, sync2_q;
   logic [4:0] level;

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         sync1_q <= SyncRst;
         sync2_q <= SyncRst;
      end else begin
         sync1_q <= {select_btn, touch_btn};
         sync2_q <= sync1_q;
      end
   end

   // 1 = pressed for every bit from here on
   assign level = {sync2_q[4], ~sync2_q[3:0]};

   // ------------------------------------------------------------------
   // Debouncers and press-edge detection
   // ------------------------------------------------------------------
   logic [DbW-1:0] db_cnt_q [5];
   logic [DbW-1:0] db_cnt_d [5];
   logic [4:0]     db_level_q, db_level_d;
   logic [4:0]     db_prev_q;
   logic [4:0]     press;

   always_comb begin
      db_level_d = db_level_q;
      for (int i = 0; i < 5; i++) begin
         db_cnt_d[i] = '0;
         if (level[i] != db_level_q[i]) begin
            // The Nth consecutive differing cycle flips the debounced level.
            if (db_cnt_q[i] == DbLast) begin
               db_level_d[i] = level[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         for (int i = 0; i < 5; i++) begin
            db_cnt_q[i] <= '0;
         end
         db_level_q <= '0;
         db_prev_q  <= '0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         db_level_q <= db_level_d;
         db_prev_q  <= db_level_q;
      end
   end

   assign press = db_level_q & ~db_prev_q;

   logic [3:0] dir_press;
   logic [3:0] dir_held;
   logic       sel_press;
   logic [1:0] press_dir;

   assign dir_press = press[3:0];
   assign dir_held  = db_level_q[3:0];
   assign sel_press = press[4];

   // Fixed priority among simultaneous presses: up > down > left > right.
   always_comb begin
      if (dir_press[0]) begin
         press_dir = DirUp;
      end else if (dir_press[1]) begin
         press_dir = DirDown;
      end else if (dir_press[2]) begin
         press_dir = DirLeft;
      end else begin
         press_dir = DirRight;
      end
   end

   // ------------------------------------------------------------------
   // Direction FSM with hold/auto-repeat timer
   // ------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [1:0]      active_q, active_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic            req;
   logic [1:0]      req_dir;

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      timer_d  = timer_q;
      req      = 1'b0;
      req_dir  = active_q;
      unique case (state_q)
         StIdle: begin
            if (|dir_press) begin
               req      = 1'b1;
               req_dir  = press_dir;
               active_d = press_dir;
               timer_d  = TmrDelay;
               state_d  = StDelay;
            end
         end
         StDelay, StRepeat: begin
            // A fresh press wins over a release seen in the same cycle so the
            // new press event is never lost.
            if (|dir_press) begin
               req      = 1'b1;
               req_dir  = press_dir;
               active_d = press_dir;
               timer_d  = TmrDelay;
               state_d  = StDelay;
            end else if (!dir_held[active_q]) begin
               timer_d = '0;
               state_d = StIdle;
            end else if (timer_q == TmrOne) begin
               req     = 1'b1;
               req_dir = active_q;
               timer_d = TmrRate;
               state_d = StRepeat;
            end else begin
               timer_d = timer_q - TmrOne;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         state_q  <= StIdle;
         active_q <= DirUp;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         timer_q  <= timer_d;
      end
   end

   // ------------------------------------------------------------------
   // Move scheduling and cursor position
   // ------------------------------------------------------------------
   // A move that coincides with a select press is held back one cycle, so
   // sel_valid is reported with the pre-move position. A move already pending
   // is applied first and any newer request takes the pending slot.
   logic       pend_q, pend_d;
   logic [1:0] pend_dir_q, pend_dir_d;
   logic       apply_valid;
   logic [1:0] apply_dir;

   assign apply_valid = pend_q | (req & ~sel_press);
   assign apply_dir   = pend_q ? pend_dir_q : req_dir;
   assign pend_d      = req & (sel_press | pend_q);
   assign pend_dir_d  = req_dir;

   logic [3:0] row_q, row_d;
   logic [3:0] col_q, col_d;
   logic       move_valid_q, move_valid_d;
   logic       sel_valid_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (apply_valid) begin
         unique case (apply_dir)
            DirUp: begin
               if (row_q != 4'd0) begin
                  row_d = row_q - 4'd1;
               end else if (WrapEn) begin
                  row_d = Last;
               end
            end
            DirDown: begin
               if (row_q != Last) begin
                  row_d = row_q + 4'd1;
               end else if (WrapEn) begin
                  row_d = 4'd0;
               end
            end
            DirLeft: begin
               if (col_q != 4'd0) begin
                  col_d = col_q - 4'd1;
               end else if (WrapEn) begin
                  col_d = Last;
               end
            end
            DirRight: begin
               if (col_q != Last) begin
                  col_d = col_q + 4'd1;
               end else if (WrapEn) begin
                  col_d = 4'd0;
               end
            end
            default: begin
               row_d = row_q;
               col_d = col_q;
            end
         endcase
      end
      // Saturated edge moves change nothing and so give no pulse.
      move_valid_d = apply_valid && ((row_d != row_q) || (col_d != col_q));
   end

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         pend_q       <= 1'b0;
         pend_dir_q   <= DirUp;
         row_q        <= '0;
         col_q        <= '0;
         move_valid_q <= 1'b0;
         sel_valid_q  <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_dir_q   <= pend_dir_d;
         row_q        <= row_d;
         col_q        <= col_d;
         move_valid_q <= move_valid_d;
         sel_valid_q  <= sel_press;
      end
   end

   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign move_valid = move_valid_q;
   assign sel_valid  = sel_valid_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl with GRID_N=10, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=5. Inputs are driven and outputs sampled on the
// falling edge. A raw press driven at a falling edge gives its first move on the
// 7th following falling edge (2 sync + 4 debounce + 1 output register).
module tb_cursor_ctrl;

`ifdef CURSOR_WRAP_EN
   localparam bit Wrap = 1'b1;
`else
   localparam bit Wrap = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_btn = 1'b1;
   logic [3:0] touch_btn = 4'hF;
   logic       select_btn = 1'b0;
   logic [3:0] cursor_row, cursor_col;
   logic       move_valid, sel_valid;

   int vectors = 0;
   int miscompares = 0;

   cursor_ctrl #(
      .GRID_N          (10),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .REPEAT_RATE     (5)
   ) dut (
      .clk        (clk),
      .reset_btn  (reset_btn),
      .touch_btn  (touch_btn),
      .select_btn (select_btn),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .move_valid (move_valid),
      .sel_valid  (sel_valid)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset_btn  = 1'b1;
      touch_btn  = 4'hF;
      select_btn = 1'b0;
      repeat (2) @(negedge clk);
      reset_btn = 1'b0;
   endtask

   // Press one direction for 'hold' cycles, watch 20 cycles.
   task automatic tap(input int dir, input int hold, input bit exp_move,
                      input logic [3:0] er, input logic [3:0] ec, input string nm);
      touch_btn[dir] = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == hold) touch_btn[dir] = 1'b1;
         vectors++;
         if (move_valid !== (exp_move && c == 7)) begin
            miscompares++;
            $display("FAIL %s move_valid c=%0d: got %b expected %b", nm, c, move_valid,
                     exp_move && c == 7);
         end
      end
      vectors++;
      if (cursor_row !== er || cursor_col !== ec) begin
         miscompares++;
         $display("FAIL %s position: got (%0d,%0d) expected (%0d,%0d)", nm, cursor_row,
                  cursor_col, er, ec);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_btn = 1'b1;
      #1;
      vectors++;
      if ({cursor_row, cursor_col, move_valid, sel_valid} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset outputs: got %b expected 0", {cursor_row, cursor_col, move_valid,
                  sel_valid});
      end
      @(negedge clk);
      reset_btn = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         vectors++;
         if ({cursor_row, cursor_col, move_valid, sel_valid} !== 10'd0) begin
            miscompares++;
            $display("FAIL post-reset idle c=%0d: got %b expected 0", c, {cursor_row,
                     cursor_col, move_valid, sel_valid});
         end
      end
   endtask

   task automatic test_debounce();
      do_reset();
      tap(3, 3, 1'b0, 4'd0, 4'd0, "glitch_3cyc");
      tap(3, 4, 1'b1, 4'd0, 4'd1, "accept_4cyc");
   endtask

   task automatic test_hold_down();
      int n;
      bit sched;
      logic [3:0] er;
      bit emv;
      n = 0;
      do_reset();
      touch_btn[1] = 1'b0;
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         sched = (c == 7) || (c >= 27 && (c - 27) % 5 == 0);
         if (sched) n++;
         er  = Wrap ? 4'(n % 10) : 4'((n > 9) ? 9 : n);
         emv = sched && (Wrap || n <= 9);
         vectors++;
         if (move_valid !== emv || cursor_row !== er || cursor_col !== 4'd0) begin
            miscompares++;
            $display("FAIL hold_down c=%0d: got mv=%b row=%0d col=%0d expected mv=%b row=%0d col=0",
                     c, move_valid, cursor_row, cursor_col, emv, er);
         end
      end
      touch_btn = 4'hF;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_wrap_up();
      do_reset();
      tap(0, 8, Wrap, Wrap ? 4'd9 : 4'd0, 4'd0, "up_at_row0");
   endtask

   task automatic test_priority();
      do_reset();
      for (int i = 1; i <= 5; i++) tap(1, 8, 1'b1, 4'(i), 4'd0, "walk_down");
      for (int i = 1; i <= 5; i++) tap(3, 8, 1'b1, 4'd5, 4'(i), "walk_right");
      touch_btn = 4'b1010;  // up and left together
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 12) touch_btn = 4'hF;
         vectors++;
         if (move_valid !== (c == 7)) begin
            miscompares++;
            $display("FAIL up_left move_valid c=%0d: got %b expected %b", c, move_valid, c == 7);
         end
      end
      vectors++;
      if (cursor_row !== 4'd4 || cursor_col !== 4'd5) begin
         miscompares++;
         $display("FAIL up_left position: got (%0d,%0d) expected (4,5)", cursor_row, cursor_col);
      end
      tap(2, 8, 1'b1, 4'd4, 4'd4, "left_again");
   endtask

   task automatic test_select_move();
      do_reset();
      tap(1, 8, 1'b1, 4'd1, 4'd0, "to_2_3");
      tap(1, 8, 1'b1, 4'd2, 4'd0, "to_2_3");
      tap(3, 8, 1'b1, 4'd2, 4'd1, "to_2_3");
      tap(3, 8, 1'b1, 4'd2, 4'd2, "to_2_3");
      tap(3, 8, 1'b1, 4'd2, 4'd3, "to_2_3");
      touch_btn[3] = 1'b0;
      select_btn   = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 8) begin
            touch_btn  = 4'hF;
            select_btn = 1'b0;
         end
         vectors++;
         if (sel_valid !== (c == 7) || move_valid !== (c == 8)) begin
            miscompares++;
            $display("FAIL sel_move pulses c=%0d: got sel=%b mv=%b expected sel=%b mv=%b", c,
                     sel_valid, move_valid, c == 7, c == 8);
         end
         if (c == 7 || c == 8) begin
            vectors++;
            if (cursor_row !== 4'd2 || cursor_col !== ((c == 7) ? 4'd3 : 4'd4)) begin
               miscompares++;
               $display("FAIL sel_move position c=%0d: got (%0d,%0d) expected (2,%0d)", c,
                        cursor_row, cursor_col, (c == 7) ? 3 : 4);
            end
         end
      end
      select_btn = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 8) select_btn = 1'b0;
         vectors++;
         if (sel_valid !== (c == 7) || move_valid !== 1'b0 || cursor_col !== 4'd4) begin
            miscompares++;
            $display("FAIL sel_only c=%0d: got sel=%b mv=%b col=%0d expected sel=%b mv=0 col=4",
                     c, sel_valid, move_valid, cursor_col, c == 7);
         end
      end
   endtask

   task automatic test_reset_midhold();
      do_reset();
      touch_btn[3] = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         vectors++;
         if (move_valid !== (c == 7 || c == 27 || c == 32)) begin
            miscompares++;
            $display("FAIL midhold move_valid c=%0d: got %b expected %b", c, move_valid,
                     c == 7 || c == 27 || c == 32);
         end
      end
      vectors++;
      if (cursor_col !== 4'd3) begin
         miscompares++;
         $display("FAIL midhold col before reset: got %0d expected 3", cursor_col);
      end
      reset_btn = 1'b1;
      #1;
      vectors++;
      if ({cursor_row, cursor_col, move_valid, sel_valid} !== 10'd0) begin
         miscompares++;
         $display("FAIL midhold async reset: got %b expected 0", {cursor_row, cursor_col,
                  move_valid, sel_valid});
      end
      @(negedge clk);
      vectors++;
      if ({cursor_row, cursor_col, move_valid, sel_valid} !== 10'd0) begin
         miscompares++;
         $display("FAIL midhold during reset: got %b expected 0", {cursor_row, cursor_col,
                  move_valid, sel_valid});
      end
      @(negedge clk);
      reset_btn = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         vectors++;
         if (move_valid !== (c == 7) || cursor_col !== ((c >= 7) ? 4'd1 : 4'd0)) begin
            miscompares++;
            $display("FAIL after reset c=%0d: got mv=%b col=%0d expected mv=%b col=%0d", c,
                     move_valid, cursor_col, c == 7, (c >= 7) ? 1 : 0);
         end
      end
      touch_btn = 4'hF;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_hold_down();
      test_wrap_up();
      test_priority();
      test_select_move();
      test_reset_midhold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d expected completion",
               vectors);
      $fatal(1, "watchdog");
   end

endmodule
